// File: rtl/board_btn_conditioner.sv
// board_btn_conditioner: front-panel input conditioner.
//   Synchronises N_BTN pushbuttons and a SW_WIDTH switch bank, debounces the
//   buttons, and produces press/release strobes, per-channel level or toggle
//   outputs, and a stretched reset request driven by button RST_CH.
// Ports:
//   clk0        - system clock, all state on the rising edge
//   rst0        - asynchronous active-low reset
//   btn_raw     - raw asynchronous button pins (active-high)
//   sw_raw      - raw asynchronous switch pins
//   btn_level   - debounced button level
//   btn_press   - one-cycle strobe on debounced 0->1
//   btn_release - one-cycle strobe on debounced 1->0
//   mode_out    - toggle state (TOGGLE_MASK bit set) or debounced level
//   sw_sync     - two-flop synchronised switches
//   rst_req     - active-high synchronous reset request to the core
module board_btn_conditioner #(
    parameter int unsigned       N_BTN           = 2,
    parameter int unsigned       SW_WIDTH        = 16,
    parameter int unsigned       DEBOUNCE_CYCLES = 1000000,
    parameter logic [N_BTN-1:0]  TOGGLE_MASK     = N_BTN'(2'b10),
    parameter int unsigned       RST_CH          = 0,
    parameter int unsigned       RST_STRETCH     = 16
) (
    input  logic                clk0,
    input  logic                rst0,
    input  logic [N_BTN-1:0]    btn_raw,
    input  logic [SW_WIDTH-1:0] sw_raw,
    output logic [N_BTN-1:0]    btn_level,
    output logic [N_BTN-1:0]    btn_press,
    output logic [N_BTN-1:0]    btn_release,
    output logic [N_BTN-1:0]    mode_out,
    output logic [SW_WIDTH-1:0] sw_sync,
    output logic                rst_req
);

    localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned RCNT_W = $clog2(RST_STRETCH + 1);
    localparam int unsigned IDX_W  = (N_BTN > 1) ? $clog2(N_BTN) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [RCNT_W-1:0] RCNT_LOAD = RCNT_W'(RST_STRETCH);
    localparam logic [IDX_W-1:0]  RST_IDX   = IDX_W'(RST_CH);

    logic [N_BTN-1:0]             btn_meta_q, btn_meta_d;
    logic [N_BTN-1:0]             btn_sync_q, btn_sync_d;
    logic [SW_WIDTH-1:0]          sw_meta_q, sw_meta_d;
    logic [SW_WIDTH-1:0]          sw_sync_q, sw_sync_d;
    logic [N_BTN-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [N_BTN-1:0]             level_q, level_d;
    logic [N_BTN-1:0]             press_q, press_d;
    logic [N_BTN-1:0]             release_q, release_d;
    logic [N_BTN-1:0]             mode_q, mode_d;
    logic [RCNT_W-1:0]            rcnt_q, rcnt_d;
    logic                         rst_req_q, rst_req_d;

    // Next-state logic: synchronisers, debounce, strobes, mode, reset stretcher
    always_comb begin
        btn_meta_d = btn_raw;
        btn_sync_d = btn_meta_q;
        sw_meta_d  = sw_raw;
        sw_sync_d  = sw_meta_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        mode_d     = mode_q;
        rcnt_d     = rcnt_q;

        for (int i = 0; i < int'(N_BTN); i++) begin
            // Any sample matching the accepted level restarts the stability count
            if (btn_sync_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = btn_sync_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end

            // Toggle channels flip one edge after the press strobe
            if (TOGGLE_MASK[i]) begin
                mode_d[i] = mode_q[i] ^ press_q[i];
            end else begin
                mode_d[i] = level_d[i];
            end
        end

        // Strobes are high in the cycle the new level is first visible
        press_d   = level_d & ~level_q;
        release_d = ~level_d & level_q;

        // A press reloads the stretch even while it is already running
        if (press_q[RST_IDX]) begin
            rcnt_d = RCNT_LOAD;
        end else if (rcnt_q != '0) begin
            rcnt_d = rcnt_q - RCNT_W'(1);
        end

        rst_req_d = (rcnt_d != '0);
    end

    // State registers; reset holds rst_req high for the power-on stretch
    always_ff @(posedge clk0 or negedge rst0) begin
        if (!rst0) begin
            btn_meta_q <= '0;
            btn_sync_q <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            cnt_q      <= '0;
            level_q    <= '0;
            press_q    <= '0;
            release_q  <= '0;
            mode_q     <= '0;
            rcnt_q     <= RCNT_LOAD;
            rst_req_q  <= 1'b1;
        end else begin
            btn_meta_q <= btn_meta_d;
            btn_sync_q <= btn_sync_d;
            sw_meta_q  <= sw_meta_d;
            sw_sync_q  <= sw_sync_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            press_q    <= press_d;
            release_q  <= release_d;
            mode_q     <= mode_d;
            rcnt_q     <= rcnt_d;
            rst_req_q  <= rst_req_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign mode_out    = mode_q;
    assign sw_sync     = sw_sync_q;
    assign rst_req     = rst_req_q;

endmodule

// File: tb/tb_board_btn_conditioner.sv
// Testbench for board_btn_conditioner: vector table, hand-written corner
// sequences and random stimulus checked against a history-window model.
module tb_board_btn_conditioner;

    localparam int unsigned N   = 2;
    localparam int unsigned SW  = 16;
    localparam int unsigned D   = 4;
    localparam int unsigned S   = 3;
    localparam int unsigned RCH = 0;
    localparam logic [1:0]  TM  = 2'b10;

    logic          clk0 = 1'b0;
    logic          rst0 = 1'b1;
    logic [N-1:0]  btn_raw = '0;
    logic [SW-1:0] sw_raw = '0;
    logic [N-1:0]  btn_level, btn_press, btn_release, mode_out;
    logic [SW-1:0] sw_sync;
    logic          rst_req;

    // Second instance with short debounce / long stretch to exercise retrigger
    logic [N-1:0]  btn_raw_b = '0;
    logic [N-1:0]  btn_level_b, btn_press_b, btn_release_b, mode_out_b;
    logic [SW-1:0] sw_sync_b;
    logic          rst_req_b;

    always #5 clk0 = ~clk0;

    board_btn_conditioner #(
        .N_BTN(N), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(D),
        .TOGGLE_MASK(TM), .RST_CH(RCH), .RST_STRETCH(S)
    ) dut (
        .clk0(clk0), .rst0(rst0), .btn_raw(btn_raw), .sw_raw(sw_raw),
        .btn_level(btn_level), .btn_press(btn_press), .btn_release(btn_release),
        .mode_out(mode_out), .sw_sync(sw_sync), .rst_req(rst_req)
    );

    board_btn_conditioner #(
        .N_BTN(N), .SW_WIDTH(SW), .DEBOUNCE_CYCLES(1),
        .TOGGLE_MASK(TM), .RST_CH(0), .RST_STRETCH(8)
    ) dut_b (
        .clk0(clk0), .rst0(rst0), .btn_raw(btn_raw_b), .sw_raw(sw_raw),
        .btn_level(btn_level_b), .btn_press(btn_press_b), .btn_release(btn_release_b),
        .mode_out(mode_out_b), .sw_sync(sw_sync_b), .rst_req(rst_req_b)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a level is accepted once the last D synchronised samples
    // all disagree with it; rst_req is high while fewer than S counted edges
    // have elapsed since the last load point (reset or press strobe + 1).
    logic [N-1:0]  m_hist[$];
    logic [N-1:0]  m_level, m_press, m_release, m_mode;
    logic [SW-1:0] m_sw, m_sw_prev;
    int            ecnt = 0;
    int            lload = 0;

    task automatic model_reset();
        m_hist.delete();
        for (int j = 0; j < int'(D) + 1; j++) m_hist.push_back('0);
        m_level   = '0;
        m_press   = '0;
        m_release = '0;
        m_mode    = '0;
        m_sw      = '0;
        m_sw_prev = '0;
        lload     = ecnt;
    endtask

    task automatic model_edge();
        logic [N-1:0] old_press;
        logic         flip;
        if (!rst0) begin
            model_reset();
            return;
        end
        ecnt++;
        old_press = m_press;
        if (old_press[RCH]) lload = ecnt;
        m_press   = '0;
        m_release = '0;
        for (int i = 0; i < int'(N); i++) begin
            // m_hist[0] is the previous edge's raw sample; synchroniser adds one more
            flip = 1'b1;
            for (int j = 1; j <= int'(D); j++) begin
                if (m_hist[j][i] == m_level[i]) flip = 1'b0;
            end
            if (flip) begin
                m_level[i] = ~m_level[i];
                if (m_level[i]) m_press[i] = 1'b1;
                else            m_release[i] = 1'b1;
            end
            if (TM[i]) begin
                if (old_press[i]) m_mode[i] = ~m_mode[i];
            end else begin
                m_mode[i] = m_level[i];
            end
        end
        m_hist.push_front(btn_raw);
        void'(m_hist.pop_back());
        m_sw      = m_sw_prev;
        m_sw_prev = sw_raw;
    endtask

    task automatic compare_model();
        check("btn_level",   32'(btn_level),   32'(m_level));
        check("btn_press",   32'(btn_press),   32'(m_press));
        check("btn_release", 32'(btn_release), 32'(m_release));
        check("mode_out",    32'(mode_out),    32'(m_mode));
        check("sw_sync",     32'(sw_sync),     32'(m_sw));
        check("rst_req",     32'(rst_req),     32'((ecnt - lload) < int'(S)));
        check("press_and_release", 32'(btn_press & btn_release), 32'(0));
    endtask

    task automatic step(input logic [N-1:0] b, input logic [SW-1:0] s);
        btn_raw = b;
        sw_raw  = s;
        @(posedge clk0);
        model_edge();
        #1;
        compare_model();
    endtask

    // Reset asserted between edges, held across one edge, released away from the edge
    task automatic do_reset(input logic [N-1:0] b);
        btn_raw = b;
        rst0 = 1'b0;
        #1;
        model_reset();
        compare_model();
        @(posedge clk0);
        model_edge();
        #1;
        compare_model();
        rst0 = 1'b1;
    endtask

    typedef struct {
        logic          rst;
        logic [N-1:0]  btn;
        logic [SW-1:0] sw;
        logic [N-1:0]  lvl;
        logic [N-1:0]  prs;
        logic [N-1:0]  rel;
        logic [N-1:0]  mode;
        logic [SW-1:0] sws;
        logic          rq;
    } vec_t;

    vec_t tbl[16];

    initial begin
        int rise_at, press_at, cnt;
        logic [N-1:0] b;
        int len;

        //            rst   btn    sw        lvl    prs    rel    mode   sw_sync   rq
        tbl[0]  = '{1'b0, 2'b11, 16'hFFFF, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1};
        tbl[1]  = '{1'b1, 2'b00, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b00, 16'h0000, 1'b1};
        tbl[2]  = '{1'b1, 2'b10, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b00, 16'hA5C3, 1'b1};
        tbl[3]  = '{1'b1, 2'b10, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b00, 16'hA5C3, 1'b0};
        tbl[4]  = '{1'b1, 2'b10, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b00, 16'hA5C3, 1'b0};
        tbl[5]  = '{1'b1, 2'b10, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b00, 16'hA5C3, 1'b0};
        tbl[6]  = '{1'b1, 2'b10, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b00, 16'hA5C3, 1'b0};
        tbl[7]  = '{1'b1, 2'b10, 16'hA5C3, 2'b10, 2'b10, 2'b00, 2'b00, 16'hA5C3, 1'b0};
        tbl[8]  = '{1'b1, 2'b10, 16'hA5C3, 2'b10, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};
        tbl[9]  = '{1'b1, 2'b00, 16'hA5C3, 2'b10, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};
        tbl[10] = '{1'b1, 2'b00, 16'hA5C3, 2'b10, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};
        tbl[11] = '{1'b1, 2'b00, 16'hA5C3, 2'b10, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};
        tbl[12] = '{1'b1, 2'b00, 16'hA5C3, 2'b10, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};
        tbl[13] = '{1'b1, 2'b00, 16'hA5C3, 2'b10, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};
        tbl[14] = '{1'b1, 2'b00, 16'hA5C3, 2'b00, 2'b00, 2'b10, 2'b10, 16'hA5C3, 1'b0};
        tbl[15] = '{1'b1, 2'b00, 16'hA5C3, 2'b00, 2'b00, 2'b00, 2'b10, 16'hA5C3, 1'b0};

        #1;
        for (int r = 0; r < 16; r++) begin
            rst0    = tbl[r].rst;
            btn_raw = tbl[r].btn;
            sw_raw  = tbl[r].sw;
            @(posedge clk0);
            #1;
            check($sformatf("vec%0d_level", r),   32'(btn_level),   32'(tbl[r].lvl));
            check($sformatf("vec%0d_press", r),   32'(btn_press),   32'(tbl[r].prs));
            check($sformatf("vec%0d_release", r), 32'(btn_release), 32'(tbl[r].rel));
            check($sformatf("vec%0d_mode", r),    32'(mode_out),    32'(tbl[r].mode));
            check($sformatf("vec%0d_sw_sync", r), 32'(sw_sync),     32'(tbl[r].sws));
            check($sformatf("vec%0d_rst_req", r), 32'(rst_req),     32'(tbl[r].rq));
        end

        // Power-on stretch with random pins held during reset
        do_reset(2'($urandom));
        for (int t = 0; t < 3; t++) begin
            step(2'b00, 16'h0000);
            check("por_stretch", 32'(rst_req), 32'(t < 2));
        end

        // Bounce rejection on channel 0: high 3, low 1, then held high
        rise_at = -1;
        cnt = 0;
        for (int t = 0; t < 16; t++) begin
            step((t < 3 || t >= 4) ? 2'b01 : 2'b00, 16'h0000);
            if (btn_level[0] && rise_at < 0) rise_at = t;
            if (btn_press[0]) cnt++;
        end
        check("bounce_rise_step", 32'(rise_at), 32'(9));
        check("bounce_press_count", 32'(cnt), 32'(1));

        // Release of channel 0 gives exactly one release strobe
        cnt = 0;
        for (int t = 0; t < 10; t++) begin
            step(2'b00, 16'h0000);
            if (btn_release[0]) cnt++;
        end
        check("release_count", 32'(cnt), 32'(1));

        // Two press/release cycles on toggle channel 1
        for (int p = 0; p < 2; p++) begin
            for (int t = 0; t < 8; t++) step(2'b10, 16'h0000);
            for (int t = 0; t < 8; t++) step(2'b00, 16'h0000);
            check("toggle_mode", 32'(mode_out[1]), 32'((p % 2) == 0));
        end

        // Retrigger on the short-debounce instance: strobes at t=2 and t=6
        for (int t = 0; t < 17; t++) begin
            btn_raw_b = (t == 0 || t >= 4) ? 2'b01 : 2'b00;
            step(2'b00, 16'h0000);
            if (t >= 2) check("retrig_rst_req", 32'(rst_req_b), 32'(t >= 3 && t <= 14));
        end
        btn_raw_b = '0;

        // Reset mid-debounce, then a simultaneous press on both channels
        do_reset(2'b00);
        for (int t = 0; t < 3; t++) step(2'b00, 16'h0000);
        for (int t = 0; t < 4; t++) step(2'b11, 16'h0000);
        do_reset(2'b11);
        press_at = -1;
        for (int t = 0; t < 8; t++) begin
            step(2'b11, 16'h0000);
            if (btn_press != 2'b00 && press_at < 0) begin
                press_at = t;
                check("both_press", 32'(btn_press), 32'(2'b11));
            end
        end
        check("press_after_reset_step", 32'(press_at), 32'(5));

        // Switch bank two-edge latency
        step(2'b11, 16'h1234);
        step(2'b11, 16'hA5C3);
        check("sw_latency_prev", 32'(sw_sync), 32'(16'h1234));
        step(2'b11, 16'hA5C3);
        check("sw_latency", 32'(sw_sync), 32'(16'hA5C3));

        // Random segments of held button patterns, occasional resets
        for (int seg = 0; seg < 120; seg++) begin
            b   = 2'($urandom);
            len = int'($urandom_range(1, 10));
            if ($urandom_range(0, 29) == 0) do_reset(2'($urandom));
            for (int t = 0; t < len; t++) step(b, 16'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/board_btn_conditioner.md
# board_btn_conditioner

Parametrised front-panel input conditioner between the board pins and `processor`. It handles N pushbuttons and a switch bank. Each button passes through a synchroniser and a debounce filter, then produces press and release strobes. Per channel, it outputs either the debounced level or a toggle state. One button channel can also drive a stretched, synchronous reset request for the processor core.

## Interface

**Parameters**
- `N_BTN`, default 2: number of button channels.
- `SW_WIDTH`, default 16: switch bank width.
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz). Legal range ≥ 1.
- `TOGGLE_MASK`, default 2'b10: bit i = 1 makes `mode_out[i]` a toggle; bit i = 0 makes it follow the debounced level.
- `RST_CH`, default 0: button channel that triggers `rst_req`.
- `RST_STRETCH`, default 16: length of `rst_req` in cycles. Legal range ≥ 1.

**Ports**
- `clk0` in 1: system clock; all state is on the rising edge.
- `rst0` in 1: asynchronous active-low reset; asserts asynchronously and deasserts on the `clk0` edge.
- `btn_raw` in N_BTN: raw asynchronous button pins, active-high.
- `sw_raw` in SW_WIDTH: raw asynchronous switch pins.
- `btn_level` out N_BTN: debounced button level.
- `btn_press` out N_BTN: one-cycle strobe on debounced 0→1.
- `btn_release` out N_BTN: one-cycle strobe on debounced 1→0.
- `mode_out` out N_BTN: toggle state or level, selected per `TOGGLE_MASK`.
- `sw_sync` out SW_WIDTH: 2-FF synchronised switches (no debounce).
- `rst_req` out 1: active-high synchronous reset request to the core.

## Operation

- **Synchroniser.** Each `btn_raw[i]` and `sw_raw[j]` passes through two flops. The second flop is the value `s[i]`.
- **Debounce.** Per channel there is a counter `cnt[i]`, `$clog2(DEBOUNCE_CYCLES+1)` bits wide.
  - If `s[i] == btn_level[i]`: `cnt[i]` ← 0.
  - Else if `cnt[i] == DEBOUNCE_CYCLES-1`: `btn_level[i]` ← `s[i]` and `cnt[i]` ← 0.
  - Else: `cnt[i]` ← `cnt[i]+1`.
  - Any glitch back to the old level before acceptance clears the count. The counter never wraps.
- **Strobes.** `btn_press[i]` and `btn_release[i]` are registered and high for exactly the one cycle in which `btn_level[i]` holds its new value. They are never both high on one channel.
- **Mode.**
  - `TOGGLE_MASK[i] = 1`: `mode_out[i]` inverts on each `btn_press[i]`.
  - `TOGGLE_MASK[i] = 0`: `mode_out[i]` equals `btn_level[i]`.
- **Reset stretcher.** A down-counter `rcnt` is `$clog2(RST_STRETCH+1)` bits wide, and `rst_req = (rcnt != 0)`.
  - `btn_press[RST_CH]` loads `rcnt` ← `RST_STRETCH`. A press during an active stretch reloads it (retrigger).
  - Otherwise, if `rcnt != 0`, it decrements.
- **Channel independence.** Channels are fully independent. Simultaneous events on several channels are all honoured in the same cycle.

**Reset values (`rst0` = 0)**
- Synchroniser flops, `cnt`, `btn_level`, `btn_press`, `btn_release`, `mode_out`, `sw_sync`: all 0.
- `rcnt` = `RST_STRETCH`, so `rst_req` = 1. This gives a power-on stretch of `RST_STRETCH` cycles after `rst0` deasserts.
- If `rst0` asserts mid-debounce or mid-stretch, all progress is discarded. After release the block restarts from the reset values above.

## Timing

- **Synchroniser latency.** A raw change set up before edge k appears on `s[i]` after edge k+1.
- **Debounce latency.** `btn_level` changes after edge k+1+DEBOUNCE_CYCLES, provided the raw input is held throughout. Total latency is DEBOUNCE_CYCLES+2 edges counted from edge k.
- **Strobes.** `btn_press`/`btn_release` are high in that same cycle only. `mode_out` updates one edge later for toggle channels and in the same cycle for level channels.
- **Reset request.** `rst_req` rises the cycle after `btn_press[RST_CH]`. It remains high for exactly `RST_STRETCH` cycles after the last press.
- **Post-reset stretch.** After `rst0` deasserts, `rst_req` stays high for `RST_STRETCH` edges, then falls.
- **Switches.** `sw_sync` latency is 2 edges.

## Test plan

Bench settings for all scenarios: DEBOUNCE_CYCLES=4, RST_STRETCH=3, N_BTN=2, TOGGLE_MASK=2'b10, RST_CH=0.

1. **Reset / power-on stretch.** Hold `rst0`=0 with random pins → all outputs 0 except `rst_req`=1. Release `rst0` → `rst_req` falls after exactly 3 edges.
2. **Clean press.** Drive `btn_raw[1]`=1 before edge k → `btn_level[1]`=1 and `btn_press[1]`=1 after edge k+5. The strobe is 1 cycle wide. `mode_out[1]` goes to 1 one edge later. A second press/release returns `mode_out[1]` to 0.
3. **Bounce rejection.** Raise `btn_raw[0]` for 3 cycles, drop it for 1, then hold it high → `btn_level[0]` rises 6 edges after the final rise, not earlier, with a single `btn_press[0]`.
4. **Release strobe and level mode.** Release a held `btn_raw[0]` → exactly one `btn_release[0]` pulse. `mode_out[0]` tracks `btn_level[0]`.
5. **Retrigger.** Press ch0, then press it again 2 cycles after `rst_req` rises → `rst_req` is held continuously and ends 3 cycles after the second press's strobe cycle.
6. **Mid-operation reset and concurrency.** Press both buttons simultaneously → `btn_press` = 2'b11 in the same cycle. Assert `rst0` mid-debounce → `cnt` clears, and after release the full latency is needed again. `sw_raw`=16'hA5C3 → `sw_sync`=16'hA5C3 after 2 edges.
